// File: rtl/axis_packet_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axis_packet_buffer_pkg                                          |
// | Purpose  : Shared stored-beat record and width helper for the packet buffer |
// | Revision : 1.0 - initial parametrised release                              |
// +----------------------------------------------------------------------------+
package axis_packet_buffer_pkg;

    // Stored word is {tlast, tstrb, tdata}.
    function automatic int beat_width(input int data_width);
        return data_width + (data_width / 8) + 1;
    endfunction

    localparam int c_default_data_width = 32;
    localparam int c_default_beat_width = beat_width(c_default_data_width);

    typedef struct packed {
        logic                                tlast;
        logic [c_default_data_width/8-1:0]   tstrb;
        logic [c_default_data_width-1:0]     tdata;
    } beat_t;

endpackage
`default_nettype wire

// File: rtl/axis_buf_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axis_buf_ram                                                    |
// | Purpose  : Simple dual-port beat store, synchronous write, async read      |
// | Revision : 1.0 - initial parametrised release                              |
// +----------------------------------------------------------------------------+
module axis_buf_ram #(
    parameter int ADDR_WIDTH = 12,
    parameter int MEM_SIZE   = 4096,
    parameter int BEAT_WIDTH = 37
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [BEAT_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [BEAT_WIDTH-1:0] o_rd_data
);

    logic [BEAT_WIDTH-1:0] r_mem [MEM_SIZE];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/axis_packet_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axis_packet_buffer                                              |
// | Purpose  : AXI-Stream buffer with optional store-and-forward packet mode   |
// | Revision : 1.0 - initial parametrised release                              |
// +----------------------------------------------------------------------------+
module axis_packet_buffer
    import axis_packet_buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int MEM_SIZE    = 4096,
    parameter bit PACKET_MODE = 1'b1
) (
    input  logic                    axis_aclk,
    input  logic                    axis_aresetn,
    input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
    input  logic                    s01_axis_tvalid,
    input  logic                    s01_axis_tlast,
    output logic                    s01_axis_tready,
    input  logic                    m01_axis_tready,
    output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
    output logic                    m01_axis_tvalid,
    output logic                    m01_axis_tlast,
    output logic [ADDR_WIDTH:0]     level,
    output logic [ADDR_WIDTH:0]     pkt_count,
    output logic                    oversize_err
);

    localparam int                  c_strb_width   = DATA_WIDTH / 8;
    localparam int                  c_stored_width = beat_width(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] c_full         = MEM_SIZE[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] c_one          = 1;

    typedef struct packed {
        logic                    tlast;
        logic [c_strb_width-1:0] tstrb;
        logic [DATA_WIDTH-1:0]   tdata;
    } stored_beat_t;

    logic [ADDR_WIDTH:0]       r_wr_ptr;
    logic [ADDR_WIDTH:0]       r_rd_ptr;
    logic [ADDR_WIDTH:0]       r_pkt_count;
    logic                      r_oversize_err;
    logic                      r_bypass;
    logic                      r_out_valid;
    stored_beat_t              r_out_beat;

    logic [ADDR_WIDTH:0]       w_level;
    logic                      w_full;
    logic                      w_wr_en;
    logic                      w_stage_free;
    logic                      w_release;
    logic                      w_load;
    logic                      w_wr_tlast;
    logic                      w_rd_tlast;
    logic                      w_oversize;
    stored_beat_t              w_wr_beat;
    stored_beat_t              w_rd_beat;
    logic [c_stored_width-1:0] w_rd_word;

    // Pointers carry a wrap bit, so their difference is the occupancy directly.
    assign w_level         = r_wr_ptr - r_rd_ptr;
    assign w_full          = (w_level == c_full);
    assign s01_axis_tready = axis_aresetn & ~w_full;
    assign w_wr_en         = s01_axis_tvalid & s01_axis_tready;
    assign w_wr_beat       = {s01_axis_tlast, s01_axis_tstrb, s01_axis_tdata};

    // In packet mode only complete packets leave, unless an oversize packet forced bypass.
    assign w_stage_free = ~r_out_valid | m01_axis_tready;
    assign w_release    = ~PACKET_MODE | (r_pkt_count != '0) | r_bypass;
    assign w_load       = w_stage_free & (w_level != '0) & w_release;
    assign w_wr_tlast   = w_wr_en & s01_axis_tlast;
    assign w_rd_tlast   = w_load & w_rd_beat.tlast;
    assign w_oversize   = PACKET_MODE & w_full & (r_pkt_count == '0);

    axis_buf_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_SIZE   (MEM_SIZE),
        .BEAT_WIDTH (c_stored_width)
    ) u_ram (
        .clk       (axis_aclk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wr_data (w_wr_beat),
        .i_rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rd_data (w_rd_word)
    );

    assign w_rd_beat = w_rd_word;

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_pkt_count    <= '0;
            r_oversize_err <= 1'b0;
            r_bypass       <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_beat     <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_one;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + c_one;
            end

            case ({w_wr_tlast, w_rd_tlast})
                2'b10:   r_pkt_count <= r_pkt_count + c_one;
                2'b01:   r_pkt_count <= r_pkt_count - c_one;
                default: r_pkt_count <= r_pkt_count;
            endcase

            // A full array holding no tlast can never release on its own.
            if (w_oversize) begin
                r_oversize_err <= 1'b1;
                r_bypass       <= 1'b1;
            end else if (w_rd_tlast) begin
                r_bypass <= 1'b0;
            end

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_beat  <= w_rd_beat;
            end else if (m01_axis_tready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign m01_axis_tvalid = r_out_valid;
    assign m01_axis_tdata  = r_out_beat.tdata;
    assign m01_axis_tstrb  = r_out_beat.tstrb;
    assign m01_axis_tlast  = r_out_beat.tlast;
    assign level           = w_level;
    assign pkt_count       = r_pkt_count;
    assign oversize_err    = r_oversize_err;

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_axis_packet_buffer                                           |
// | Purpose  : Directed bench; instance 0 cut-through, instance 1 packet mode  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_axis_packet_buffer;

    localparam int DW = 32;
    localparam int SW = 4;
    localparam int AW = 3;
    localparam int MS = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] s_tdata  [2];
    logic [SW-1:0] s_tstrb  [2];
    logic          s_tvalid [2];
    logic          s_tlast  [2];
    logic          s_tready [2];
    logic          m_tready [2];
    logic [DW-1:0] m_tdata  [2];
    logic [SW-1:0] m_tstrb  [2];
    logic          m_tvalid [2];
    logic          m_tlast  [2];
    logic [AW:0]   level    [2];
    logic [AW:0]   pkt_cnt  [2];
    logic          ovf      [2];

    axis_packet_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS), .PACKET_MODE(1'b0)) u_dut_ct (
        .axis_aclk(clk), .axis_aresetn(rstn),
        .s01_axis_tdata(s_tdata[0]), .s01_axis_tstrb(s_tstrb[0]), .s01_axis_tvalid(s_tvalid[0]),
        .s01_axis_tlast(s_tlast[0]), .s01_axis_tready(s_tready[0]), .m01_axis_tready(m_tready[0]),
        .m01_axis_tdata(m_tdata[0]), .m01_axis_tstrb(m_tstrb[0]), .m01_axis_tvalid(m_tvalid[0]),
        .m01_axis_tlast(m_tlast[0]), .level(level[0]), .pkt_count(pkt_cnt[0]), .oversize_err(ovf[0])
    );

    axis_packet_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS), .PACKET_MODE(1'b1)) u_dut_pm (
        .axis_aclk(clk), .axis_aresetn(rstn),
        .s01_axis_tdata(s_tdata[1]), .s01_axis_tstrb(s_tstrb[1]), .s01_axis_tvalid(s_tvalid[1]),
        .s01_axis_tlast(s_tlast[1]), .s01_axis_tready(s_tready[1]), .m01_axis_tready(m_tready[1]),
        .m01_axis_tdata(m_tdata[1]), .m01_axis_tstrb(m_tstrb[1]), .m01_axis_tvalid(m_tvalid[1]),
        .m01_axis_tlast(m_tlast[1]), .level(level[1]), .pkt_count(pkt_cnt[1]), .oversize_err(ovf[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: beats held in the array as a queue, plus the single output slot.
    logic [36:0] mq [2][$];
    logic [36:0] rx [2][$];
    logic        mv   [2] = '{1'b0, 1'b0};
    logic [36:0] mb   [2] = '{37'd0, 37'd0};
    logic        mbyp [2] = '{1'b0, 1'b0};
    logic        movf [2] = '{1'b0, 1'b0};

    function automatic int n_tlast(input int i);
        int n = 0;
        for (int k = 0; k < mq[i].size(); k++) if (mq[i][k][36]) n++;
        return n;
    endfunction

    initial forever begin
        @(posedge clk or negedge rstn);
        for (int i = 0; i < 2; i++) begin
            int sz, nt;
            bit acc, rel, ld;
            if (!rstn) begin
                mq[i].delete();
                mv[i] = 1'b0; mb[i] = '0; mbyp[i] = 1'b0; movf[i] = 1'b0;
            end else begin
                sz  = mq[i].size();
                nt  = n_tlast(i);
                acc = s_tvalid[i] && (sz < MS);
                rel = (i == 0) || (nt > 0) || mbyp[i];
                ld  = (!mv[i] || m_tready[i]) && (sz > 0) && rel;
                if (i == 1 && sz == MS && nt == 0) begin
                    movf[i] = 1'b1;
                    mbyp[i] = 1'b1;
                end
                if (ld) begin
                    mb[i] = mq[i].pop_front();
                    mv[i] = 1'b1;
                    if (mb[i][36]) mbyp[i] = 1'b0;
                end else if (m_tready[i]) begin
                    mv[i] = 1'b0;
                end
                if (acc) mq[i].push_back({s_tlast[i], s_tstrb[i], s_tdata[i]});
            end
        end
    end

    logic        prev_stall [2] = '{1'b0, 1'b0};
    logic [37:0] prev_out   [2];

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("tvalid%0d", i), m_tvalid[i], mv[i]);
            if (mv[i]) begin
                chk($sformatf("tdata%0d", i), m_tdata[i], mb[i][31:0]);
                chk($sformatf("tstrb%0d", i), m_tstrb[i], mb[i][35:32]);
                chk($sformatf("tlast%0d", i), m_tlast[i], mb[i][36]);
            end
            chk($sformatf("level%0d", i), level[i], mq[i].size());
            chk($sformatf("pkt_count%0d", i), pkt_cnt[i], n_tlast(i));
            chk($sformatf("oversize%0d", i), ovf[i], movf[i]);
            chk($sformatf("s_tready%0d", i), s_tready[i], (mq[i].size() != MS) && rstn);
            if (prev_stall[i] && rstn)
                chk($sformatf("stall_hold%0d", i), {m_tvalid[i], m_tlast[i], m_tstrb[i], m_tdata[i]}, prev_out[i]);
            prev_stall[i] = rstn && m_tvalid[i] && !m_tready[i];
            prev_out[i]   = {m_tvalid[i], m_tlast[i], m_tstrb[i], m_tdata[i]};
            if (rstn && m_tvalid[i] && m_tready[i]) rx[i].push_back({m_tlast[i], m_tstrb[i], m_tdata[i]});
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input int i, input logic [31:0] d, input logic [3:0] st, input logic last);
        bit took;
        int waited = 0;
        s_tdata[i] = d; s_tstrb[i] = st; s_tlast[i] = last; s_tvalid[i] = 1'b1;
        do begin
            took = s_tready[i];
            @(posedge clk); #2;
            waited++;
        end while (!took && waited < 200);
        chk($sformatf("send_accept%0d", i), took, 1'b1);
        s_tvalid[i] = 1'b0;
    endtask

    task automatic wait_rx(input int i, input int n);
        int w = 0;
        while (rx[i].size() < n && w < 300) begin
            @(posedge clk); #2;
            w++;
        end
        chk($sformatf("rx_count%0d", i), rx[i].size(), n);
    endtask

    logic [31:0] exp2 [3] = '{32'h55, 32'h22, 32'h24};

    initial begin
        int acc;
        bit took;
        for (int i = 0; i < 2; i++) begin
            s_tvalid[i] = 1'b0; s_tdata[i] = '0; s_tstrb[i] = '0; s_tlast[i] = 1'b0; m_tready[i] = 1'b0;
        end

        // Reset and release
        cycles(3);
        for (int i = 0; i < 2; i++) chk("rst_tready_low", s_tready[i], 1'b0);
        rstn = 1'b1;
        cycles(1);
        for (int i = 0; i < 2; i++) begin
            chk("rst_tvalid", m_tvalid[i], 1'b0);
            chk("rst_tdata", m_tdata[i], 0);
            chk("rst_tstrb", m_tstrb[i], 0);
            chk("rst_tlast", m_tlast[i], 1'b0);
            chk("rst_level", level[i], 0);
            chk("rst_pkt_count", pkt_cnt[i], 0);
            chk("rst_oversize", ovf[i], 1'b0);
            chk("rst_tready_high", s_tready[i], 1'b1);
        end

        // Cut-through, consumer stalled, then released
        for (int k = 0; k < 3; k++) send(0, exp2[k], 4'hF, 1'b1);
        chk("t2_level_peak", level[0], 2);
        m_tready[0] = 1'b1;
        wait_rx(0, 3);
        for (int k = 0; k < 3; k++) begin
            chk("t2_order", rx[0][k][31:0], exp2[k]);
            chk("t2_tlast", rx[0][k][36], 1'b1);
        end
        cycles(2);
        chk("t2_level_drained", level[0], 0);
        m_tready[0] = 1'b0;
        rx[0].delete();

        // Packet mode holds until tlast
        m_tready[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send(1, 32'h10 + k, 4'hF, 1'b0);
            chk("t3_held", m_tvalid[1], 1'b0);
        end
        send(1, 32'h13, 4'hF, 1'b1);
        chk("t3_held_last", m_tvalid[1], 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycles(1);
            chk("t3_valid", m_tvalid[1], 1'b1);
            chk("t3_data", m_tdata[1], 32'h10 + k);
            chk("t3_tlast", m_tlast[1], k == 3);
        end
        cycles(1);
        chk("t3_idle", m_tvalid[1], 1'b0);
        rx[1].delete();

        // Fill to capacity with consumer stalled
        acc = 0;
        for (int c = 0; c < 16; c++) begin
            s_tvalid[0] = (acc < 12); s_tdata[0] = 100 + acc; s_tlast[0] = 1'b0; s_tstrb[0] = 4'hF;
            took = s_tvalid[0] && s_tready[0];
            cycles(1);
            if (took) acc++;
        end
        chk("t4_accepted", acc, 9);
        chk("t4_tready_full", s_tready[0], 1'b0);
        chk("t4_level_full", level[0], 8);
        m_tready[0] = 1'b1;
        cycles(1);
        m_tready[0] = 1'b0;
        chk("t4_tready_after_pop", s_tready[0], 1'b1);
        took = s_tvalid[0] && s_tready[0];
        cycles(1);
        chk("t4_extra_write", took, 1'b1);
        chk("t4_level_refull", level[0], 8);
        s_tvalid[0] = 1'b0;
        m_tready[0] = 1'b1;
        wait_rx(0, 10);
        for (int k = 0; k < 10; k++) chk("t4_order", rx[0][k][31:0], 100 + k);
        cycles(2);
        rx[0].delete();

        // Streaming with a toggling consumer
        fork
            begin
                for (int k = 0; k < 32; k++) send(0, k, k[3:0], (k % 4) == 3);
            end
            begin
                int c = 0;
                while (rx[0].size() < 32 && c < 500) begin
                    m_tready[0] = ~m_tready[0];
                    cycles(1);
                    c++;
                end
                m_tready[0] = 1'b1;
            end
        join
        chk("t5_count", rx[0].size(), 32);
        for (int k = 0; k < 32 && k < rx[0].size(); k++) chk("t5_order", rx[0][k], {((k % 4) == 3), k[3:0], k[31:0]});

        // Oversize packet recovery in packet mode
        m_tready[1] = 1'b1;
        for (int k = 0; k < 8; k++) send(1, 32'h200 + k, 4'hF, 1'b0);
        chk("t6_level_full", level[1], 8);
        chk("t6_tready_full", s_tready[1], 1'b0);
        send(1, 32'h208, 4'hF, 1'b0);
        send(1, 32'h209, 4'hF, 1'b1);
        chk("t6_oversize", ovf[1], 1'b1);
        wait_rx(1, 10);
        for (int k = 0; k < 10 && k < rx[1].size(); k++) begin
            chk("t6_order", rx[1][k][31:0], 32'h200 + k);
            chk("t6_tlast", rx[1][k][36], k == 9);
        end
        send(1, 32'h300, 4'hF, 1'b0);
        cycles(3);
        chk("t6_next_held", m_tvalid[1], 1'b0);
        chk("t6_next_level", level[1], 1);
        send(1, 32'h301, 4'hF, 1'b1);
        wait_rx(1, 12);
        if (rx[1].size() >= 12) begin
            chk("t6_next_a", rx[1][10][31:0], 32'h300);
            chk("t6_next_b", rx[1][11][31:0], 32'h301);
        end
        chk("t6_sticky", ovf[1], 1'b1);

        // Asynchronous reset with a packet and a partial packet stored
        m_tready[1] = 1'b0;
        cycles(2);
        send(1, 32'h400, 4'hF, 1'b1);
        send(1, 32'h401, 4'hF, 1'b1);
        send(1, 32'h402, 4'hF, 1'b0);
        chk("t6_pre_rst_level", level[1], 2);
        chk("t6_pre_rst_pkt", pkt_cnt[1], 1);
        #1 rstn = 1'b0;
        #1;
        chk("t6_rst_level", level[1], 0);
        chk("t6_rst_pkt", pkt_cnt[1], 0);
        chk("t6_rst_tvalid", m_tvalid[1], 1'b0);
        chk("t6_rst_oversize", ovf[1], 1'b0);
        cycles(2);
        rstn = 1'b1;
        cycles(3);
        chk("t6_post_rst_level", level[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_packet_buffer.md
Name: axis_packet_buffer

Overview:
- Single-clock AXI-Stream buffer memory: accepts beats on a slave port, stores data, tstrb and tlast in an internal array, and replays them in order on a master port.
- Parametrised successor to the team's fixed memory wrapper, generalised in width and depth.
- Adds a selectable store-and-forward packet mode, an occupancy/packet status output and oversize-packet recovery.
- Sits between a stream producer (DMA or processing core) and a consumer that must not see partial packets.

Parameters:
DATA_WIDTH, 32, tdata width in bits; multiple of 8
ADDR_WIDTH, 12, address width of the storage array
MEM_SIZE, 4096, array depth in beats; must equal 2**ADDR_WIDTH
PACKET_MODE, 1, 1 = store-and-forward (release only complete packets); 0 = cut-through

Ports:
axis_aclk  in  1  clock for both stream interfaces
axis_aresetn  in  1  asynchronous active-low reset
s01_axis_tdata  in  DATA_WIDTH  write data
s01_axis_tstrb  in  DATA_WIDTH/8  byte strobes, stored with the data
s01_axis_tvalid  in  1  write beat valid
s01_axis_tlast  in  1  last beat of packet
s01_axis_tready  out  1  buffer can accept a beat
m01_axis_tready  in  1  consumer ready
m01_axis_tdata  out  DATA_WIDTH  read data
m01_axis_tstrb  out  DATA_WIDTH/8  read strobes
m01_axis_tvalid  out  1  output beat valid
m01_axis_tlast  out  1  last beat of packet
level  out  ADDR_WIDTH+1  beats held in the array (output register excluded)
pkt_count  out  ADDR_WIDTH+1  complete packets held in the array
oversize_err  out  1  sticky: packet-mode packet exceeded capacity

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - wr_ptr, rd_ptr, level, pkt_count, oversize_err and bypass are cleared.
  - All m01_* outputs are 0; s01_axis_tready is 0 while reset is asserted.
  - Array contents are not reset. Reset mid-packet discards all stored beats, including any partial packet.
- Pointers are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - Empty: pointers equal.
  - Full: address bits equal and MSBs differ, equivalently level == MEM_SIZE.
- s01_axis_tready = (level != MEM_SIZE). It is combinational from registered state and never depends on s01_axis_tvalid.
- Write: on tvalid & tready, store {tlast, tstrb, tdata} at wr_ptr and increment wr_ptr. pkt_count increments if tlast = 1.
- Output stage: a single register. It loads from array[rd_ptr] (asynchronous array read) when all of the following hold:
  - the stage is empty, or m01_axis_tvalid & m01_axis_tready in this cycle;
  - level != 0;
  - PACKET_MODE == 0, or pkt_count != 0, or bypass == 1.
- On load: increment rd_ptr and set m01_axis_tvalid. If the loaded beat has tlast = 1, decrement pkt_count and clear bypass.
- If the stage is consumed and nothing is loaded in the same cycle, m01_axis_tvalid falls to 0.
- Latency: a beat accepted at edge N is presented after edge N+1.
  - Cut-through: applies to every beat.
  - Packet mode: the first beat appears at the edge after the packet's tlast beat is accepted.
- m01_* outputs stay stable while m01_axis_tvalid & !m01_axis_tready.
- Simultaneous write and load: level unchanged. Simultaneous tlast write and tlast load: pkt_count unchanged.
- Simultaneous write and load at full: legal only when the load frees a slot in the same cycle. tready is computed from registered level, so no write is accepted at full; the slot is usable on the next cycle.
- Oversize condition: PACKET_MODE = 1, level == MEM_SIZE and pkt_count == 0.
  - oversize_err is set (sticky until reset) and bypass is set.
  - bypass releases beats cut-through until a tlast beat is loaded, so the buffer never deadlocks.
- tstrb is passed through unmodified; it is not interpreted.

Decomposition:
- Shared package holds the stored-beat record type {tlast, tstrb, tdata} and a BEAT_WIDTH constant derived from DATA_WIDTH.
- One natural sub-module: axis_buf_ram, a simple dual-port array (synchronous write, asynchronous read) of MEM_SIZE x BEAT_WIDTH.
- Pointer logic, counters and the output stage stay in the top level.

Test Plan:
1. Hold axis_aresetn = 0, then release → all m01_* = 0, level = 0, pkt_count = 0, oversize_err = 0, s01_axis_tready = 1 on the first cycle after release.
2. PACKET_MODE = 0, m01_axis_tready = 0; write 0x0055, 0x0022, 0x0024, each with tlast = 1 and tstrb = 0xF; then raise m01_axis_tready → output order is 0x55, 0x22, 0x24 with tlast = 1 on each. level peaks at 2 (first beat sits in the output register) and returns to 0.
3. PACKET_MODE = 1, m01_axis_tready = 1; write 0x10..0x13 with tlast on 0x13 → m01_axis_tvalid stays 0 through the first three writes. Four consecutive beats 0x10..0x13 start one cycle after 0x13 is accepted; tlast = 1 on 0x13 only.
4. MEM_SIZE = 8, ADDR_WIDTH = 3, PACKET_MODE = 0, m01_axis_tready = 0; offer 12 beats → exactly 9 accepted (8 array + 1 output register), s01_axis_tready = 0 and level = 8. Pulsing m01_axis_tready for one cycle pops one beat; one more write is accepted on the following cycle.
5. Toggle m01_axis_tready every cycle while streaming 0..31 → no beat lost or duplicated, and m01_* stay stable during every stall cycle.
6. MEM_SIZE = 8, PACKET_MODE = 1, m01_axis_tready = 1; write a 10-beat packet with tlast on beat 10 → oversize_err = 1 once level reaches 8. All 10 beats emerge in order; bypass clears after beat 10; a following 2-beat packet is held until its tlast is accepted. Asserting reset mid-packet afterwards clears level and pkt_count immediately.
